pipelined_shifter: RTL

Parametrised, pipelined barrel shifter. It replaces the fixed 32-bit combinational arithmetic-right shifter in the ALU datapath. Supports four shift modes, any power-of-two width, and a tag sideband. Uses a valid/ready handshake with full backpressure and a synchronous flush, so it can sit in the execute stage of the multi-cycle processor.

---
 rtl/shift_pkg.sv | 12 +
 rtl/shift_stage.sv | 104 ++++++++++
 rtl/pipelined_shifter.sv | 103 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shifter datapath and ALU decode.
//   shift_op_e : shift mode encoding (SLL, SRL, SRA, ROR)
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// One stage of the pipelined barrel shifter: a single 2^STAGE mux layer
// followed by its pipeline register and advance logic.
// Ports:
//   clock, reset_n, flush        : clock, async active-low reset, sync kill
//   valid_i / ready_c_o          : upstream handshake (ready is combinational)
//   ready_i                      : downstream stage (or consumer) can take data
//   data_i, shamt_i, op_i, tag_i : upstream payload; shamt_i[0] is this stage's bit
//   valid_o, data_o, shamt_o,
//   op_o, tag_o                  : registered payload towards the next stage
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned STAGE   = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               valid_i,
    output logic               ready_c_o,
    input  logic               ready_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_e          op_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output shift_op_e          op_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int unsigned AMT = 32'd1 << STAGE;

    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    shift_op_e          op_q,    op_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;
    logic [WIDTH-1:0]   shifted;

    // Mux layer: shift by 2^STAGE when the lowest remaining shamt bit is set.
    always_comb begin
        shifted = data_i;
        if (shamt_i[0]) begin
            case (op_i)
                SHIFT_SLL: shifted = data_i << AMT;
                SHIFT_SRL: shifted = data_i >> AMT;
                SHIFT_SRA: shifted = WIDTH'($signed(data_i) >>> AMT);
                SHIFT_ROR: shifted = (data_i >> AMT) | (data_i << (WIDTH - AMT));
                default:   shifted = data_i;
            endcase
        end
    end

    // Empty stages accept even while downstream stalls, so bubbles collapse.
    assign ready_c_o = ~valid_q | ready_i;

    // Next state: load on advance, hold otherwise; flush kills validity only.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        if (ready_c_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d  = shifted;
                shamt_d = shamt_i >> 1;
                op_d    = op_i;
                tag_d   = tag_i;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= SHIFT_SLL;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake,
// full backpressure, synchronous flush and a pass-through tag.
// Ports:
//   clock, reset_n, flush               : clock, async active-low reset, sync kill
//   in_valid, in_ready                  : input handshake (in_ready combinational)
//   in_data, in_shamt, in_op, in_tag    : operation
//   out_valid, out_ready                : output handshake
//   out_data, out_tag, out_zero         : result, its tag, result-is-zero flag
module pipelined_shifter
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned TAG_W   = 5,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    // Stage chain; per-stage wires keep the ready path free of false loops.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic               v_up;
        logic [WIDTH-1:0]   d_up;
        logic [SHAMT_W-1:0] s_up;
        shift_op_e          o_up;
        logic [TAG_W-1:0]   t_up;
        logic               rdy_dn;

        logic               valid;
        logic               ready;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        shift_op_e          op;
        logic [TAG_W-1:0]   tag;

        if (k == 0) begin : g_head
            assign v_up = in_valid;
            assign d_up = in_data;
            assign s_up = in_shamt;
            assign o_up = shift_op_e'(in_op);
            assign t_up = in_tag;
        end else begin : g_body
            assign v_up = g_stage[k-1].valid;
            assign d_up = g_stage[k-1].data;
            assign s_up = g_stage[k-1].shamt;
            assign o_up = g_stage[k-1].op;
            assign t_up = g_stage[k-1].tag;
        end

        if (k == SHAMT_W - 1) begin : g_tail
            assign rdy_dn = out_ready;
        end else begin : g_link
            assign rdy_dn = g_stage[k+1].ready;
        end

        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .STAGE   (k)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush     (flush),
            .valid_i   (v_up),
            .ready_c_o (ready),
            .ready_i   (rdy_dn),
            .data_i    (d_up),
            .shamt_i   (s_up),
            .op_i      (o_up),
            .tag_i     (t_up),
            .valid_o   (valid),
            .data_o    (data),
            .shamt_o   (shamt),
            .op_o      (op),
            .tag_o     (tag)
        );
    end

    // Flush must refuse the input presented alongside it.
    assign in_ready  = g_stage[0].ready & ~flush;
    assign out_valid = g_stage[SHAMT_W-1].valid;
    assign out_data  = g_stage[SHAMT_W-1].data;
    assign out_tag   = g_stage[SHAMT_W-1].tag;
    assign out_zero  = (out_data == '0);

    // Shamt/op have no consumer after the last stage.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHAMT_W-1].shamt, g_stage[SHAMT_W-1].op};

endmodule
